// File: rtl/fir_response_checker.sv
// ============================================================================
// fir_response_checker
//
// Purpose:
//   Watches the output stream of a fir_filter that has been driven with a
//   single impulse of amplitude amp. Once armed by start, it waits for the
//   response onset (the first valid sample whose magnitude exceeds tol).
//   It compares TAPS samples against round(amp*coef[k] / 2^COEF_FRAC).
//   It then checks that TAIL_LEN further samples are within tol of zero.
//   Finally it reports a verdict.
//
// Ports:
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset
//   start         - arm pulse; latches amp and tol (ignored while busy)
//   amp           - signed impulse amplitude that was driven into the filter
//   tol           - unsigned absolute tolerance per sample
//   valid_in      - filter valid_out
//   data_in       - filter data_out (signed)
//   busy          - test in progress (ARMED, COMPARE or TAIL)
//   done          - verdict available; held until the next accepted start
//   pass          - no mismatches and no timeout (meaningful while done)
//   timeout       - onset not seen within WAIT_MAX cycles of arming
//   err_count     - saturating mismatch count
//   first_err_idx - sample index of the first mismatch, 8'hFF if none
// ============================================================================
module fir_response_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int TAPS       = 32,
    parameter int COEF_FRAC  = 15,
    parameter int TAIL_LEN   = 16,
    parameter int WAIT_MAX   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] amp,
    input  logic        [7:0]            tol,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic        [15:0]           err_count,
    output logic        [7:0]            first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COMPARE,
        S_TAIL,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_TAP  = 8'(TAPS - 1);
    localparam logic [7:0]  LAST_TAIL = 8'(TAPS + TAIL_LEN - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

    localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ~SAT_MAX;

    // Impulse response of the filter under test, in Q(COEF_FRAC) format.
    function automatic logic signed [COEF_WIDTH-1:0] coef_at(input logic [4:0] idx);
        logic signed [COEF_WIDTH-1:0] c;
        case (idx)
            5'd0:  c = COEF_WIDTH'(415);
            5'd1:  c = COEF_WIDTH'(1251);
            5'd2:  c = COEF_WIDTH'(2017);
            5'd3:  c = COEF_WIDTH'(2876);
            5'd4:  c = COEF_WIDTH'(3725);
            5'd5:  c = COEF_WIDTH'(4428);
            5'd6:  c = COEF_WIDTH'(4858);
            5'd7:  c = COEF_WIDTH'(4957);
            5'd8:  c = COEF_WIDTH'(4615);
            5'd9:  c = COEF_WIDTH'(3904);
            5'd10: c = COEF_WIDTH'(2872);
            5'd11: c = COEF_WIDTH'(1671);
            5'd12: c = COEF_WIDTH'(471);
            5'd13: c = COEF_WIDTH'(-557);
            5'd14: c = COEF_WIDTH'(-1307);
            5'd15: c = COEF_WIDTH'(-1694);
            5'd16: c = COEF_WIDTH'(-1697);
            5'd17: c = COEF_WIDTH'(-1374);
            5'd18: c = COEF_WIDTH'(-842);
            5'd19: c = COEF_WIDTH'(-245);
            5'd20: c = COEF_WIDTH'(298);
            5'd21: c = COEF_WIDTH'(702);
            5'd22: c = COEF_WIDTH'(900);
            5'd23: c = COEF_WIDTH'(876);
            5'd24: c = COEF_WIDTH'(708);
            5'd25: c = COEF_WIDTH'(405);
            5'd26: c = COEF_WIDTH'(110);
            5'd27: c = COEF_WIDTH'(-144);
            5'd28: c = COEF_WIDTH'(-317);
            5'd29: c = COEF_WIDTH'(-382);
            5'd30: c = COEF_WIDTH'(-369);
            5'd31: c = COEF_WIDTH'(-454);
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] amp_r;
    logic        [7:0]            tol_r;
    logic        [7:0]            k;
    logic        [15:0]           wait_cnt;

    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [ACC_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]  biased;
    logic signed [ACC_WIDTH-1:0]  rounded;
    logic signed [DATA_WIDTH-1:0] exp_val;
    logic signed [DATA_WIDTH:0]   diff;
    logic        [DATA_WIDTH:0]   abs_diff;
    logic        [DATA_WIDTH:0]   abs_data;
    logic        [DATA_WIDTH:0]   tol_ext;
    logic                         mismatch;
    logic                         onset;
    logic                         accept;
    logic        [15:0]           err_next;
    logic        [7:0]            idx_next;

    // Expected sample: round-half-up of amp*coef, saturated to the sample
    // range. In the tail the expectation is zero. The difference is taken one
    // bit wider than a sample so that its magnitude can never overflow.
    always_comb begin
        coef    = coef_at(k[4:0]);
        product = $signed({{(ACC_WIDTH-DATA_WIDTH){amp_r[DATA_WIDTH-1]}}, amp_r}) *
                  $signed({{(ACC_WIDTH-COEF_WIDTH){coef[COEF_WIDTH-1]}}, coef});
        biased  = product + ROUND_HALF;
        rounded = biased >>> COEF_FRAC;

        if (rounded > SAT_MAX) begin
            exp_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            exp_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            exp_val = rounded[DATA_WIDTH-1:0];
        end
        if (state == S_TAIL) begin
            exp_val = '0;
        end

        diff     = {data_in[DATA_WIDTH-1], data_in} - {exp_val[DATA_WIDTH-1], exp_val};
        abs_diff = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        abs_data = data_in[DATA_WIDTH-1] ? $unsigned(-{data_in[DATA_WIDTH-1], data_in})
                                         : $unsigned({1'b0, data_in});
        tol_ext  = (DATA_WIDTH+1)'(tol_r);
        mismatch = abs_diff > tol_ext;
        onset    = valid_in && (abs_data > tol_ext);

        accept = ((state == S_ARMED) && onset) ||
                 (((state == S_COMPARE) || (state == S_TAIL)) && valid_in);

        err_next = err_count;
        idx_next = first_err_idx;
        if (accept && mismatch) begin
            if (err_count != 16'hFFFF) begin
                err_next = err_count + 16'd1;
            end
            if (first_err_idx == 8'hFF) begin
                idx_next = k;
            end
        end
    end

    // Test sequencer. All outputs are registered and change together with the
    // state, so done/pass appear the cycle after the final accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            amp_r         <= '0;
            tol_r         <= '0;
            k             <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 8'hFF;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_ARMED;
                        amp_r         <= amp;
                        tol_r         <= tol;
                        k             <= '0;
                        wait_cnt      <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= 8'hFF;
                    end
                end

                // Small valid samples before the onset are treated as the
                // filter still flushing and are not compared.
                S_ARMED: begin
                    if (accept) begin
                        err_count     <= err_next;
                        first_err_idx <= idx_next;
                        k             <= k + 8'd1;
                        state         <= S_COMPARE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_COMPARE: begin
                    if (accept) begin
                        err_count     <= err_next;
                        first_err_idx <= idx_next;
                        k             <= k + 8'd1;
                        if (k == LAST_TAP) begin
                            state <= S_TAIL;
                        end
                    end
                end

                S_TAIL: begin
                    if (accept) begin
                        err_count     <= err_next;
                        first_err_idx <= idx_next;
                        k             <= k + 8'd1;
                        if (k == LAST_TAIL) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 16'd0) && !timeout;
                            state <= S_DONE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_response_checker.sv
// ============================================================================
// tb_fir_response_checker
//
// Purpose:
//   Drives directed impulse-response streams into fir_response_checker. Each
//   run pushes its expected verdict into a scoreboard queue. A separate monitor
//   pops and compares a verdict whenever the DUT raises done.
//
// Ports: none (top-level bench).
// ============================================================================
module tb_fir_response_checker;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] amp;
    logic        [7:0]  tol;
    logic               valid_in;
    logic signed [15:0] data_in;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic        [15:0] err_count;
    logic        [7:0]  first_err_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit pass;
        bit timeout;
        int err;
        int idx;
    } verdict_t;

    verdict_t sb_q[$];
    logic     done_q = 1'b0;

    int coef_tb[32] = '{415, 1251, 2017, 2876, 3725, 4428, 4858, 4957, 4615, 3904,
                        2872, 1671, 471, -557, -1307, -1694, -1697, -1374, -842, -245,
                        298, 702, 900, 876, 708, 405, 110, -144, -317, -382, -369, -454};

    fir_response_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .amp           (amp),
        .tol           (tol),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal filter output, computed with real arithmetic and floor rounding.
    function automatic int model(input int a, input int i);
        real r;
        r = $floor((real'(a) * real'(coef_tb[i]) + 16384.0) / 32768.0);
        if (r > 32767.0) r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: one verdict per rising edge of done.
    always @(negedge clk) begin
        if (rst_n && done && !done_q) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_verdict", 1, 0);
            end else begin
                verdict_t v;
                v = sb_q.pop_front();
                checkOutput("verdict_pass", int'(pass), int'(v.pass));
                checkOutput("verdict_timeout", int'(timeout), int'(v.timeout));
                checkOutput("verdict_err_count", int'(err_count), v.err);
                checkOutput("verdict_first_err_idx", int'(first_err_idx), v.idx);
                checkOutput("verdict_busy", int'(busy), 0);
            end
        end
        done_q = done;
    end

    // One complete run: arm, 5 idle cycles, two ignorable pre-response samples
    // (0 and exactly tol), then TAPS+TAIL_LEN samples with optional deltas.
    // busy_start_idx injects a start pulse; abort_idx pulls reset instead of
    // feeding that sample. Negative indices disable those features.
    task automatic applyStimulus(input int amp_v, input int tol_v, input bit gap,
                                 input int fa_idx, input int fa_d,
                                 input int fb_idx, input int fb_d,
                                 input int busy_start_idx, input int abort_idx,
                                 input bit exp_pass, input int exp_err, input int exp_idx);
        int v;
        @(negedge clk);
        start = 1'b1;
        amp   = 16'(amp_v);
        tol   = 8'(tol_v);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("done_after_start", int'(done), 0);
        repeat (4) @(negedge clk);
        if (abort_idx < 0) begin
            sb_q.push_back('{exp_pass, 1'b0, exp_err, exp_idx});
        end
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = (p == 0) ? 16'sd0 : 16'(tol_v);
        end
        for (int i = 0; i < 48; i++) begin
            if (i == abort_idx) begin
                @(negedge clk);
                valid_in = 1'b0;
                checkOutput("abort_err_before_reset", int'(err_count), exp_err);
                rst_n = 1'b0;
                #1;
                checkOutput("abort_busy", int'(busy), 0);
                checkOutput("abort_done", int'(done), 0);
                checkOutput("abort_err_count", int'(err_count), 0);
                checkOutput("abort_first_err_idx", int'(first_err_idx), 8'hFF);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            v = (i < 32) ? model(amp_v, i) : 0;
            if (i == fa_idx) v += fa_d;
            if (i == fb_idx) v += fb_d;
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = 16'(v);
            start    = (i == busy_start_idx);
            if (i == busy_start_idx) begin
                checkOutput("busy_during_compare", int'(busy), 1);
                amp = -16'sd1000;
                tol = 8'd0;
            end
            if (gap) begin
                @(negedge clk);
                valid_in = 1'b0;
                start    = 1'b0;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        start    = 1'b0;
        checkOutput("done_one_cycle_after_last", int'(done), 1);
    endtask

    task automatic runTimeout();
        @(negedge clk);
        start = 1'b1;
        amp   = 16'sd1000;
        tol   = 8'd2;
        sb_q.push_back('{1'b0, 1'b1, 0, 255});
        @(negedge clk);
        start = 1'b0;
        repeat (63) @(negedge clk);
        checkOutput("timeout_not_yet", int'(done), 0);
        @(negedge clk);
        checkOutput("timeout_done", int'(done), 1);
        checkOutput("timeout_flag", int'(timeout), 1);
        checkOutput("timeout_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        amp      = '0;
        tol      = '0;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_pass", int'(pass), 0);
        checkOutput("reset_timeout", int'(timeout), 0);
        checkOutput("reset_err_count", int'(err_count), 0);
        checkOutput("reset_first_err_idx", int'(first_err_idx), 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] nominal pass");
        applyStimulus(1000, 2, 1'b0, -1, 0, -1, 0, -1, -1, 1'b1, 0, 255);

        $display("[TB] single fault at k=7, k=3 off by exactly tol");
        applyStimulus(1000, 2, 1'b0, 7, 5, 3, 2, -1, -1, 1'b0, 1, 7);

        $display("[TB] gapped stream with tail fault at index 40");
        applyStimulus(1000, 2, 1'b1, 40, 5, -1, 0, -1, -1, 1'b0, 1, 40);

        $display("[TB] timeout");
        runTimeout();

        $display("[TB] start while busy");
        applyStimulus(1000, 2, 1'b0, -1, 0, -1, 0, 10, -1, 1'b1, 0, 255);

        $display("[TB] reset mid-test then negative amplitude");
        applyStimulus(1000, 2, 1'b0, 3, 9, -1, 0, -1, 10, 1'b0, 1, 3);
        applyStimulus(-1000, 2, 1'b0, -1, 0, -1, 0, -1, -1, 1'b1, 0, 255);

        for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_response_checker.md
Name: fir_response_checker

Overview:
- Sits at the output end of the fir_filter stream and consumes its data_out/valid_out samples.
- Once armed, it finds the onset of the filter's impulse response and compares each following sample against amp*coef[k], rounded and scaled back to data width.
- It then checks that the tail has settled to zero.
- It reports a pass/fail verdict, an error count and the index of the first mismatch, for in-system self-test of the multiplierless filters.

Parameters:
DATA_WIDTH, 16, sample width (signed)
COEF_WIDTH, 16, ROM coefficient width (signed)
ACC_WIDTH, 32, width of the amp*coef product
TAPS, 32, coefficient count / compared response length
COEF_FRAC, 15, fractional bits of the coefficients
TAIL_LEN, 16, post-response samples that must be ~0
WAIT_MAX, 64, cycles allowed in ARMED before timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  arm pulse; samples amp and tol
amp  in  DATA_WIDTH  signed impulse amplitude driven into the filter
tol  in  8  unsigned absolute tolerance per sample
valid_in  in  1  connects to filter valid_out
data_in  in  DATA_WIDTH  connects to filter data_out (signed)
busy  out  1  high in ARMED, COMPARE or TAIL
done  out  1  level; high in DONE until the next accepted start
pass  out  1  meaningful only while done: 1 = no error and no timeout
timeout  out  1  onset not seen within WAIT_MAX cycles
err_count  out  16  mismatch count, saturates at 16'hFFFF
first_err_idx  out  8  sample index of the first mismatch; 8'hFF if none

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously forces state IDLE; all outputs 0 except first_err_idx=8'hFF.
  - Reset mid-operation abandons the test; there is no verdict.
- Coefficient ROM, indexed 0..31, in this order: 415,1251,2017,2876,3725,4428,4858,4957,4615,3904,2872,1671,471,-557,-1307,-1694,-1697,-1374,-842,-245,298,702,900,876,708,405,110,-144,-317,-382,-369,-454.
- Expected value (combinational from the registered index k):
  - exp = (amp_r*coef[k] + 2^(COEF_FRAC-1)) >>> COEF_FRAC.
  - Signed ACC_WIDTH arithmetic, arithmetic shift (round-half-up), then saturated to the DATA_WIDTH signed range.
  - In TAIL, exp=0.
- Mismatch: |data_in - exp| > tol_r, computed at DATA_WIDTH+1 bits so the subtraction cannot overflow.
- IDLE:
  - start -> ARMED.
  - Latch amp_r and tol_r; clear k, err_count, timeout and the wait counter; set first_err_idx=8'hFF.
- ARMED:
  - Increment the wait counter every cycle.
  - On valid_in with |data_in| > tol_r, this sample is k=0: compare it, set k=1, go to COMPARE.
  - If the wait counter reaches WAIT_MAX first: timeout=1, go to DONE.
  - Valid samples at or below tol are ignored as pre-response.
- COMPARE:
  - Each valid_in cycle compares sample k, then k++.
  - The edge that accepts k=TAPS-1 goes to TAIL.
  - valid_in low holds all state (no timeout here).
- TAIL:
  - Compares TAIL_LEN valid samples against 0, with sample indices TAPS..TAPS+TAIL_LEN-1.
  - The edge that accepts the last tail sample goes to DONE.
- Counters and outputs:
  - err_count and first_err_idx update on the same edge that accepts the offending sample.
  - first_err_idx is written only while it is 8'hFF.
  - done and pass become visible in the cycle after the final accepted sample.
  - pass = (err_count==0) && !timeout.
- DONE: outputs hold. start re-arms exactly as from IDLE, so done drops on the next cycle.
- start while busy is ignored.
- Constraint: TAPS+TAIL_LEN <= 255.

Test Plan:
- Nominal pass:
  - Stimulus: start with amp=1000, tol=2; after 5 idle cycles, feed a valid stream of the ideal response, which includes 13 (k=0), 151 (k=7) and -14 (k=31), followed by 16 zeros.
  - Required: done=1 one cycle after the last zero; pass=1; err_count=0; first_err_idx=8'hFF.
- Single fault:
  - Stimulus: same as nominal, but sample k=7 is 156 instead of 151.
  - Required: err_count=1; first_err_idx=7; pass=0.
- Gapped stream with a tail fault:
  - Stimulus: valid_in toggles 1,0,1,0 throughout; tail sample index 40 is 5.
  - Required: all indices still align; first_err_idx=40; err_count=1.
- Timeout:
  - Stimulus: start, then valid_in held at 0.
  - Required: timeout=1 and done=1 after 64 cycles; pass=0; busy=0.
- Start while busy:
  - Stimulus: start pulse during COMPARE.
  - Required: ignored; the test completes with the original amp and tol.
- Reset mid-test:
  - Stimulus: rst_n low at k=10, then restart with amp=-1000.
  - Required: outputs cleared immediately; the new run passes against the negated expectations (k=0 -> -13).
